// File: rtl/router_dest_reader_if.sv
// Bundle of router-FIFO-side and client-side signals for one router output port.
// slave = the reader block, master = whatever drives the router FIFO and the client.
interface router_dest_reader_if #(
  parameter int CNT_W = 16
);
  logic             vld_out;
  logic [7:0]       data_out;
  logic             soft_reset;
  logic             read_enb;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             pkt_ready;
  logic             pkt_sop;
  logic             pkt_eop;
  logic             pkt_done;
  logic             parity_err;
  logic             addr_err;
  logic             pkt_abort;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] drop_count;

  modport slave (
    input  vld_out, data_out, soft_reset, pkt_ready,
    output read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_done,
           parity_err, addr_err, pkt_abort, pkt_count, drop_count
  );

  modport master (
    output vld_out, data_out, soft_reset, pkt_ready,
    input  read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_done,
           parity_err, addr_err, pkt_abort, pkt_count, drop_count
  );
endinterface

// File: rtl/router_dest_reader.sv
// Destination reader for one router output port: drains the FIFO, checks header/parity,
// forwards payload over valid/ready. Define STALL_GUARD_EN to force reads on a stalled client.
module router_dest_reader #(
  parameter int PORT_ID     = 0,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 25
) (
  input logic                 clock,
  input logic                 resetn,
  router_dest_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, PARITY = 2'd2} state_t;

  localparam logic [1:0] PORT_ADDR = 2'(PORT_ID);

  // The synchronizer flushes the FIFO after 30 idle cycles, so the forced read must come first.
  if (STALL_LIMIT < 1 || STALL_LIMIT >= 30) begin : g_bad_stall_limit
    $error("STALL_LIMIT must be in 1..29");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic             rd_pend_q;
  logic [5:0]       len_q, cnt_q;
  logic [1:0]       addr_q;
  logic [7:0]       par_q;
  logic             done_q, perr_q, aerr_q, abort_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [7:0]       buf_data_q [2];
  logic [1:0]       buf_sop_q, buf_eop_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;

  logic       space, force_rd, drop_byte, corrupt;
  logic       read_en, arrive, push, pop, fin, par_bad, addr_bad;
  logic [7:0] rx;

  assign rx       = bus.data_out;
  // A pending read already owns a buffer slot even if it turns out to be header or parity.
  assign space    = ({1'b0, occ_q} + {2'b00, rd_pend_q}) < 3'd2;
  assign read_en  = resetn & bus.vld_out & ~bus.soft_reset & (space | force_rd);
  assign arrive   = rd_pend_q & ~bus.soft_reset & ~drop_byte;
  assign pop      = (occ_q != 2'd0) & bus.pkt_ready;
  assign par_bad  = (par_q != rx) | corrupt;
  assign addr_bad = (addr_q != PORT_ADDR);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.soft_reset) begin
      state_d = IDLE;
    end else if (arrive) begin
      case (state_q)
        IDLE:    state_d = (rx[7:2] != 6'd0) ? PAYLOAD : PARITY;
        PAYLOAD: if (cnt_q == len_q - 6'd1) state_d = PARITY;
        PARITY:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push = 1'b0;
    fin  = 1'b0;
    if (arrive) begin
      push = (state_q == PAYLOAD);
      fin  = (state_q == PARITY);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      aerr_q    <= 1'b0;
      abort_q   <= 1'b0;
      pkt_cnt_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      rd_pend_q <= read_en;
      done_q    <= fin;
      perr_q    <= fin & par_bad;
      aerr_q    <= fin & addr_bad;
      abort_q   <= bus.soft_reset & (state_q != IDLE);
      if (fin & ~par_bad & ~addr_bad) pkt_cnt_q <= sat_inc(pkt_cnt_q);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Datapath holds no reset; every field is loaded before it is consumed.
  always_ff @(posedge clock) begin
    if (arrive && state_q == IDLE) begin
      len_q  <= rx[7:2];
      addr_q <= rx[1:0];
      par_q  <= rx;
      cnt_q  <= 6'd0;
    end
    if (push) begin
      par_q                <= par_q ^ rx;
      cnt_q                <= cnt_q + 6'd1;
      buf_data_q[wr_ptr_q] <= rx;
      buf_sop_q[wr_ptr_q]  <= (cnt_q == 6'd0);
      buf_eop_q[wr_ptr_q]  <= (cnt_q == len_q - 6'd1);
    end
  end

`ifdef STALL_GUARD_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0]    stall_q;
  logic             drop_pend_q, corrupt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  assign force_rd  = (stall_q == SW'(STALL_LIMIT));
  assign drop_byte = drop_pend_q;
  assign corrupt   = corrupt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q     <= '0;
      drop_pend_q <= 1'b0;
      corrupt_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (bus.vld_out & ~read_en) begin
        if (!force_rd) stall_q <= stall_q + SW'(1);
      end else begin
        stall_q <= '0;
      end
      // Only a forced read can be issued without buffer space; its byte is thrown away.
      drop_pend_q <= read_en & ~space;
      if (drop_pend_q) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (bus.soft_reset | fin) corrupt_q <= 1'b0;
      else if (drop_pend_q)     corrupt_q <= 1'b1;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign force_rd       = 1'b0;
  assign drop_byte      = 1'b0;
  assign corrupt        = 1'b0;
  assign bus.drop_count = '0;
`endif

  assign bus.read_enb   = read_en;
  assign bus.pkt_valid  = (occ_q != 2'd0);
  assign bus.pkt_data   = (occ_q != 2'd0) ? buf_data_q[rd_ptr_q] : 8'd0;
  assign bus.pkt_sop    = (occ_q != 2'd0) & buf_sop_q[rd_ptr_q];
  assign bus.pkt_eop    = (occ_q != 2'd0) & buf_eop_q[rd_ptr_q];
  assign bus.pkt_done   = done_q;
  assign bus.parity_err = perr_q;
  assign bus.addr_err   = aerr_q;
  assign bus.pkt_abort  = abort_q;
  assign bus.pkt_count  = pkt_cnt_q;
endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: router FIFO model, packet vector table, scoreboard on the client side.
`timescale 1ns/1ps
module tb_router_dest_reader;
  localparam int CNT_W   = 16;
  localparam int PORT_ID = 1;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  router_dest_reader_if #(.CNT_W(CNT_W)) bus ();

  router_dest_reader #(.PORT_ID(PORT_ID), .CNT_W(CNT_W), .STALL_LIMIT(25)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] hdr; bit bad_par; bit exp_perr; bit exp_aerr; } vec_t;
  typedef struct { logic [7:0] data; logic sop; logic eop; } beat_t;
  typedef struct { logic perr; logic aerr; } done_t;

  beat_t      exp_beats [$];
  done_t      exp_done  [$];
  logic [7:0] fifo      [$];

  int n_checks    = 0;
  int n_fail      = 0;
  int aborts_seen = 0;
  int dones_seen  = 0;
  bit mon_en      = 1'b0;
  logic [CNT_W-1:0] exp_count = '0;
  beat_t mon_b;
  done_t mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Router output FIFO: data appears the cycle after read_enb is sampled; soft_reset flushes it.
  always @(posedge clock) begin
    if (bus.soft_reset) fifo.delete();
    else if (bus.read_enb && fifo.size() > 0) bus.data_out <= fifo.pop_front();
  end

  always @(negedge clock) bus.vld_out = (fifo.size() != 0);

  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.pkt_valid && bus.pkt_ready) begin
        check("beat_expected", 32'(exp_beats.size() > 0), 32'd1);
        if (exp_beats.size() > 0) begin
          mon_b = exp_beats.pop_front();
          check("beat", 32'({bus.pkt_data, bus.pkt_sop, bus.pkt_eop}),
                32'({mon_b.data, mon_b.sop, mon_b.eop}));
        end
      end
      if (bus.pkt_done) begin
        dones_seen++;
        check("done_expected", 32'(exp_done.size() > 0), 32'd1);
        check("done_abort_overlap", 32'(bus.pkt_abort), 32'd0);
        if (exp_done.size() > 0) begin
          mon_d = exp_done.pop_front();
          check("parity_err", 32'(bus.parity_err), 32'(mon_d.perr));
          check("addr_err", 32'(bus.addr_err), 32'(mon_d.aerr));
        end
      end
      if (bus.pkt_abort) aborts_seen++;
    end
  end

  task automatic send_pkt(input logic [7:0] hdr, input bit bad_par, input bit exp_perr, input bit exp_aerr);
    int         len = int'(hdr[7:2]);
    logic [7:0] par = hdr;
    logic [7:0] p;
    beat_t      b;
    done_t      d;
    fifo.push_back(hdr);
    for (int k = 0; k < len; k++) begin
      p = 8'((k + 1) * 17);
      par ^= p;
      b.data = p;
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      exp_beats.push_back(b);
      fifo.push_back(p);
    end
    fifo.push_back(bad_par ? (par ^ 8'h01) : par);
    d.perr = exp_perr;
    d.aerr = exp_aerr;
    exp_done.push_back(d);
    if (!exp_perr && !exp_aerr) exp_count++;
  endtask

  task automatic drain(input string name, input bit rnd_ready);
    int cyc = 0;
    while ((exp_beats.size() != 0 || exp_done.size() != 0 || fifo.size() != 0) && cyc < 2000) begin
      @(posedge clock);
      #1;
      if (rnd_ready) bus.pkt_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    bus.pkt_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check({"drain_", name}, 32'(cyc >= 2000), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  vecs [8];
    beat_t b;
    int    ab0, dn0;

    // {header, corrupt parity byte, expected parity_err, expected addr_err}; DUT serves port 1
    vecs = '{
      '{8'h0D, 1'b0, 1'b0, 1'b0},   // len 3 good packet
      '{8'h0D, 1'b1, 1'b1, 1'b0},   // len 3 bad parity
      '{8'h0C, 1'b0, 1'b0, 1'b1},   // address 0 on port 1
      '{8'h01, 1'b0, 1'b0, 1'b0},   // zero length: bytes 0x01,0x01
      '{8'h15, 1'b0, 1'b0, 1'b0},   // len 5
      '{8'hFD, 1'b0, 1'b0, 1'b0},   // len 63 maximum
      '{8'h02, 1'b1, 1'b1, 1'b1},   // zero length, both errors
      '{8'h0E, 1'b0, 1'b0, 1'b1}    // len 3 address 2
    };

    bus.soft_reset = 1'b0;
    bus.pkt_ready  = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_read_enb",   32'(bus.read_enb),   32'd0);
    check("rst_pkt_valid",  32'(bus.pkt_valid),  32'd0);
    check("rst_pkt_data",   32'(bus.pkt_data),   32'd0);
    check("rst_pkt_sop",    32'(bus.pkt_sop),    32'd0);
    check("rst_pkt_eop",    32'(bus.pkt_eop),    32'd0);
    check("rst_pkt_done",   32'(bus.pkt_done),   32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    check("rst_addr_err",   32'(bus.addr_err),   32'd0);
    check("rst_pkt_abort",  32'(bus.pkt_abort),  32'd0);
    check("rst_pkt_count",  32'(bus.pkt_count),  32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_pkt(vecs[i].hdr, vecs[i].bad_par, vecs[i].exp_perr, vecs[i].exp_aerr);
      drain($sformatf("vec%0d", i), i >= 4);
      check($sformatf("pkt_count_vec%0d", i), 32'(bus.pkt_count), 32'(exp_count));
    end

    // Client stalled: only header plus two payload bytes may leave the FIFO.
    bus.pkt_ready = 1'b0;
    send_pkt(8'h15, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("bp_fifo_left",    32'(fifo.size()),   32'd4);
    check("bp_valid_held",   32'(bus.pkt_valid), 32'd1);
    check("bp_read_enb_low", 32'(bus.read_enb),  32'd0);
    bus.pkt_ready = 1'b1;
    drain("bp", 1'b0);
    check("bp_pkt_count", 32'(bus.pkt_count), 32'(exp_count));

    // Soft reset after two payload bytes of a len 4 packet.
    fifo.push_back(8'h11);
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    b = '{8'h11, 1'b1, 1'b0};
    exp_beats.push_back(b);
    b = '{8'h22, 1'b0, 1'b0};
    exp_beats.push_back(b);
    drain("sr_pre", 1'b0);
    ab0 = aborts_seen;
    dn0 = dones_seen;
    bus.soft_reset = 1'b1;
    @(posedge clock);
    #1;
    bus.soft_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("sr_abort_pulse", 32'(aborts_seen - ab0), 32'd1);
    check("sr_no_done",     32'(dones_seen - dn0),  32'd0);

    // Soft reset while idle must not report an abort.
    bus.soft_reset = 1'b1;
    @(posedge clock);
    #1;
    bus.soft_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("sr_idle_no_abort", 32'(aborts_seen - ab0), 32'd1);

    send_pkt(8'h0D, 1'b0, 1'b0, 1'b0);
    drain("sr_post", 1'b1);
    check("sr_pkt_count", 32'(bus.pkt_count), 32'(exp_count));
    check("drop_count_off", 32'(bus.drop_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/router_dest_reader.md
Name: router_dest_reader

Overview:
- Destination-side consumer for one 1x3 router output port.
- Monitors vld_out_x and drives read_enb_x so the synchronizer's 30-cycle soft-reset timer never fires under normal flow.
- Parses each packet read from the output FIFO, checks the address and parity, and forwards the payload bytes to a downstream client over valid/ready.
- One instance per output port; PORT_ID selects which port it serves.

Parameters:
- PORT_ID, 0, expected header address field (0..2) for this port.
- CNT_W, 16, width of the packet/drop statistics counters.
- STALL_LIMIT, 25, max cycles vld_out may stay high without a read before a forced read (STALL_GUARD_EN only; must be < 30).

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- vld_out  in  1  FIFO non-empty, from router
- data_out  in  8  FIFO read data; valid the cycle after read_enb is sampled high
- soft_reset  in  1  FIFO flush from the synchronizer for this port
- read_enb  out  1  FIFO read strobe, at most one pop per cycle
- pkt_data  out  8  payload byte to client
- pkt_valid  out  1  pkt_data valid
- pkt_ready  in  1  client accepts when pkt_valid & pkt_ready
- pkt_sop  out  1  qualifies the first payload byte
- pkt_eop  out  1  qualifies the last payload byte
- pkt_done  out  1  1-cycle pulse when the parity byte has been consumed
- parity_err  out  1  valid with pkt_done; computed parity != received parity
- addr_err  out  1  valid with pkt_done; header[1:0] != PORT_ID
- pkt_abort  out  1  1-cycle pulse when a packet is killed by soft_reset
- pkt_count  out  CNT_W  good packets (no parity/addr error), saturating
- drop_count  out  CNT_W  bytes discarded by the stall guard, saturating; tied 0 when the feature is off

Behaviour:
- Reset (resetn low, asynchronous):
  - All outputs 0.
  - State IDLE, output buffer empty, counters 0, rd_pend 0.
- Packet format:
  - Header byte: len = hdr[7:2] (0..63), addr = hdr[1:0].
  - Then len payload bytes, then one parity byte.
  - Parity = XOR of the header byte and all payload bytes.
- Read issue:
  - read_enb = vld_out & ~soft_reset & (buf_occ + rd_pend < 2), where buf_occ is the 2-entry output buffer occupancy.
  - rd_pend is a register holding the previous cycle's read_enb, cleared by soft_reset.
  - A byte arrives when rd_pend = 1; sample data_out in that cycle.
- FSM, advancing on each arriving byte:
  - IDLE: the first arrival is the header. Latch len/addr, par = hdr, byte_cnt = 0. Go to PAYLOAD if len > 0, else PARITY.
  - PAYLOAD: par ^= byte; push {byte, sop = (byte_cnt == 0), eop = (byte_cnt == len-1)} into the buffer; byte_cnt++. Go to PARITY after byte len.
  - PARITY: compare par with the received byte. Next cycle: pkt_done = 1, parity_err/addr_err valid. pkt_count++ if no error. Return to IDLE.
- Header and parity bytes never enter the buffer, so a zero-length packet produces pkt_done only.
- Payload bytes are forwarded even on addr_err; the client discards them on the error flag.
- Output buffer:
  - 2-entry FIFO; pkt_valid = buffer non-empty; pkt_data/sop/eop come from the head entry.
  - Push and pop in the same cycle is allowed.
  - Read gating ensures no overflow; the buffer never drops bytes.
- soft_reset high in any cycle:
  - The in-flight byte is discarded and the FSM returns to IDLE.
  - pkt_abort pulses next cycle if the state was not IDLE.
  - Bytes already in the buffer drain normally; the aborted packet gets no eop and no pkt_done.
- Counters saturate at all-ones and do not wrap.
- pkt_done and pkt_abort are never both high in the same cycle.

Optional Feature:
- Macro: STALL_GUARD_EN.
- Defined:
  - A stall counter increments while vld_out = 1 and read_enb = 0, and clears otherwise.
  - When it reaches STALL_LIMIT, read_enb is forced high for one cycle regardless of buffer space.
  - The returned byte is discarded, drop_count++, and the FSM takes no action on it. The current packet is marked corrupt: parity_err = 1 at pkt_done.
- Undefined:
  - No stall counter; drop_count is constant 0.
  - A stalled client can let the router soft-reset the FIFO.

Test Plan:
- Good packet: PORT_ID=0; FIFO holds 0x0C,0x11,0x22,0x33,0x0C; pkt_ready=1.
  -> Beats 0x11(sop), 0x22, 0x33(eop); pkt_done with parity_err=0, addr_err=0; pkt_count=1.
- Bad parity: same packet with parity 0x0D.
  -> 3 beats forwarded; pkt_done with parity_err=1; pkt_count stays 0.
- Address mismatch: PORT_ID=1, header 0x0C.
  -> addr_err=1 at pkt_done; pkt_count=0.
- Zero-length: PORT_ID=1; bytes 0x01,0x01.
  -> No pkt_valid; pkt_done with parity_err=0, addr_err=0; pkt_count=1.
- Backpressure: 5-byte payload; pkt_ready=0 for 10 cycles.
  -> read_enb low once 2 bytes are buffered; no byte lost or duplicated; all 5 beats delivered in order after pkt_ready rises.
- Soft reset: assert soft_reset for 1 cycle after 2 payload bytes of len=4.
  -> pkt_abort pulse, FSM IDLE, no pkt_done; the next good packet completes with pkt_count incremented.
